// File: rtl/sha256_block_feeder.sv
// SHA-256 block feeder: collects 32-bit message words, applies SHA-256 padding
// and hands 512-bit blocks plus the chaining value to an external compression core.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   start, msg_len            begin a message of msg_len 32-bit words (sampled in IDLE)
//   in_data, in_valid         message word stream, big-endian, first word first
//   in_ready                  high in FILL; transfer when in_valid && in_ready
//   blk_start                 one-cycle pulse to the core, blk_data/blk_h valid
//   blk_data                  padded block, word 0 in bits 511:480
//   blk_h                     chaining value to the core, H0 in bits 255:224
//   blk_hash, blk_done        core result (feed-forward included) and done pulse
//   digest, done              final hash and one-cycle completion pulse
//   busy                      high in every state except IDLE
module sha256_block_feeder #(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             blk_start,
    output logic [511:0]     blk_data,
    output logic [255:0]     blk_h,
    input  logic [255:0]     blk_hash,
    input  logic             blk_done,
    output logic [255:0]     digest,
    output logic             done,
    output logic             busy
);

    localparam logic [255:0] ShaIv = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [2:0] {StIdle, StFill, StPad, StIssue, StWait} state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] left_q, left_d;
    // Five bits: after the marker lands in word 15 the index reads 16.
    logic [4:0]       idx_q, idx_d;
    logic             marker_q, marker_d;
    logic             final_q, final_d;
    logic [31:0]      buf_q [16];
    logic [31:0]      buf_d [16];
    logic [255:0]     h_q, h_d;
    logic [255:0]     digest_q, digest_d;
    logic             done_q, done_d;

    logic [63:0]      len_bits;
    logic [4:0]       pad_idx;

    // Message length in bits, zero-extended to the 64-bit SHA-256 length field.
    assign len_bits = 64'(len_q) << 5;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        left_d   = left_q;
        idx_d    = idx_q;
        marker_d = marker_q;
        final_d  = final_q;
        buf_d    = buf_q;
        h_d      = h_q;
        digest_d = digest_q;
        done_d   = 1'b0;
        pad_idx  = idx_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d    = msg_len;
                    left_d   = msg_len;
                    idx_d    = 5'd0;
                    marker_d = 1'b0;
                    final_d  = 1'b0;
                    for (int i = 0; i < 16; i++) buf_d[i] = 32'h0;
                    h_d      = ShaIv;
                    state_d  = (msg_len != '0) ? StFill : StPad;
                end
            end
            StFill: begin
                if (in_valid) begin
                    buf_d[idx_q[3:0]] = in_data;
                    idx_d  = idx_q + 5'd1;
                    left_d = left_q - LEN_W'(1);
                    if (idx_q == 5'd15) begin
                        final_d = 1'b0;
                        state_d = StIssue;
                    end else if (left_q == LEN_W'(1)) begin
                        state_d = StPad;
                    end
                end
            end
            StPad: begin
                if (!marker_q) begin
                    buf_d[idx_q[3:0]] = 32'h8000_0000;
                    marker_d = 1'b1;
                    pad_idx  = idx_q + 5'd1;
                end
                // Length only fits if words 14-15 are still free; otherwise it
                // goes into an extra, otherwise all-zero block.
                if (pad_idx <= 5'd14) begin
                    buf_d[14] = len_bits[63:32];
                    buf_d[15] = len_bits[31:0];
                    final_d   = 1'b1;
                end else begin
                    final_d   = 1'b0;
                end
                idx_d   = pad_idx;
                state_d = StIssue;
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (blk_done) begin
                    h_d = blk_hash;
                    if (final_q) begin
                        digest_d = blk_hash;
                        done_d   = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        for (int i = 0; i < 16; i++) buf_d[i] = 32'h0;
                        idx_d   = 5'd0;
                        state_d = (left_q != '0) ? StFill : StPad;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            len_q    <= '0;
            left_q   <= '0;
            idx_q    <= 5'd0;
            marker_q <= 1'b0;
            final_q  <= 1'b0;
            for (int i = 0; i < 16; i++) buf_q[i] <= 32'h0;
            h_q      <= 256'h0;
            digest_q <= 256'h0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            left_q   <= left_d;
            idx_q    <= idx_d;
            marker_q <= marker_d;
            final_q  <= final_d;
            for (int i = 0; i < 16; i++) buf_q[i] <= buf_d[i];
            h_q      <= h_d;
            digest_q <= digest_d;
            done_q   <= done_d;
        end
    end

    // The buffer is untouched during ISSUE/WAIT, so it drives the core directly.
    always_comb begin
        blk_data = 512'h0;
        for (int i = 0; i < 16; i++) blk_data[511-32*i -: 32] = buf_q[i];
    end

    assign in_ready  = (state_q == StFill);
    assign blk_start = (state_q == StIssue);
    assign busy      = (state_q != StIdle);
    assign blk_h     = h_q;
    assign digest    = digest_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sha256_block_feeder.sv
// Scoreboard bench for sha256_block_feeder with a behavioural SHA-256 core.
module tb_sha256_block_feeder;

    localparam int LEN_W = 16;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [255:0] DIG_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_ABCD =
        256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [LEN_W-1:0] msg_len;
    logic [31:0]      in_data;
    logic             in_valid;
    logic             in_ready;
    logic             blk_start;
    logic [511:0]     blk_data;
    logic [255:0]     blk_h;
    logic [255:0]     blk_hash;
    logic             blk_done;
    logic [255:0]     digest;
    logic             done;
    logic             busy;

    always #5 clk = ~clk;

    sha256_block_feeder #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .msg_len   (msg_len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .blk_start (blk_start),
        .blk_data  (blk_data),
        .blk_h     (blk_h),
        .blk_hash  (blk_hash),
        .blk_done  (blk_done),
        .digest    (digest),
        .done      (done),
        .busy      (busy)
    );

    int n_vec = 0;
    int n_err = 0;
    int blk_cnt = 0;
    bit core_en = 1'b1;
    bit core_busy = 1'b0;
    logic [255:0] core_hv;

    logic [511:0] exp_blk_q [$];
    logic [255:0] exp_h_q [$];
    logic [255:0] exp_dig_q [$];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got timeout/unexpected event, expected none", name);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Plain FIPS 180-4 compression with feed-forward.
    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = m[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    // Behavioural compression core with random latency.
    initial begin
        blk_done = 1'b0;
        blk_hash = 256'h0;
        forever begin
            @(negedge clk);
            if (blk_start && core_en && reset_n) begin
                core_busy = 1'b1;
                core_hv = sha_compress(blk_h, blk_data);
                repeat ($urandom_range(1, 4)) @(negedge clk);
                core_busy = 1'b0;
                blk_hash = core_hv;
                blk_done = 1'b1;
                @(negedge clk);
                blk_done = 1'b0;
                blk_hash = {8{$urandom}};
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a block or a digest.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (blk_start) begin
                    blk_cnt++;
                    if (exp_blk_q.size() == 0) fail_now("unexpected_blk_start");
                    else begin
                        chk("blk_data", blk_data, exp_blk_q.pop_front());
                        chk("blk_h", 512'(blk_h), 512'(exp_h_q.pop_front()));
                    end
                end
                if (blk_start || core_busy) chk("in_ready_issue_wait", 512'(in_ready), 512'(0));
                if (done) begin
                    if (exp_dig_q.size() == 0) fail_now("unexpected_done");
                    else chk("digest", 512'(digest), 512'(exp_dig_q.pop_front()));
                end
            end
        end
    end

    task automatic wait_idle();
        int cyc = 0;
        while (busy && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (busy) fail_now("wait_idle");
    endtask

    task automatic send_msg(input int len, input bit gaps, input bit hold, input bit fixed,
                            input logic [255:0] fixed_dig);
        logic [31:0]  words [$];
        logic [31:0]  pad [$];
        logic [63:0]  lenb;
        logic [255:0] h;
        logic [511:0] blk;
        int           k, cyc, b0, exp_nb;
        bit           xfer;

        for (int i = 0; i < len; i++) words.push_back(fixed ? 32'h61626364 : $urandom);
        // Reference padding: message, 0x80 marker word, zeros to 448 mod 512, bit length.
        pad = words;
        pad.push_back(32'h8000_0000);
        while (pad.size() % 16 != 14) pad.push_back(32'h0);
        lenb = 64'(len) << 5;
        pad.push_back(lenb[63:32]);
        pad.push_back(lenb[31:0]);
        h = IV;
        for (int b = 0; b < pad.size() / 16; b++) begin
            for (int j = 0; j < 16; j++) blk[511-32*j -: 32] = pad[16*b+j];
            exp_blk_q.push_back(blk);
            exp_h_q.push_back(h);
            h = sha_compress(h, blk);
        end
        exp_dig_q.push_back(h);
        exp_nb = len / 16 + (((len % 16) <= 13) ? 1 : 2);

        wait_idle();
        b0 = blk_cnt;
        @(negedge clk);
        start = 1'b1;
        msg_len = LEN_W'(len);
        @(negedge clk);
        if (!hold) start = 1'b0;
        msg_len = LEN_W'($urandom);

        k = 0;
        cyc = 0;
        while (k < len && cyc < 4000) begin
            if (in_ready) begin
                if (gaps && ($urandom % 3 == 0)) begin
                    in_valid = 1'b0;
                    in_data = $urandom;
                end else begin
                    in_valid = 1'b1;
                    in_data = words[k];
                end
            end else begin
                in_valid = 1'($urandom);
                in_data = $urandom;
            end
            xfer = in_valid && in_ready;
            if (xfer) k++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        if (k < len) fail_now("feed_timeout");

        cyc = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!done) fail_now("done_timeout");
        if (fixed) chk("known_digest", 512'(digest), 512'(fixed_dig));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("digest_stable", 512'(digest), 512'(h));
            chk("idle_after_done", 512'(busy), 512'(0));
        end
        chk("block_count", 512'(blk_cnt - b0), 512'(exp_nb));
    endtask

    initial begin
        int cyc;
        reset_n = 1'b0;
        start = 1'b0;
        msg_len = '0;
        in_valid = 1'b0;
        in_data = 32'h0;
        #2;
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_in_ready", 512'(in_ready), 512'(0));
        chk("rst_blk_start", 512'(blk_start), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        chk("rst_blk_data", blk_data, 512'(0));
        chk("rst_blk_h", 512'(blk_h), 512'(0));
        chk("rst_digest", 512'(digest), 512'(0));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        send_msg(0, 1'b0, 1'b0, 1'b1, DIG_EMPTY);
        send_msg(1, 1'b0, 1'b0, 1'b1, DIG_ABCD);
        send_msg(14, 1'b0, 1'b0, 1'b0, 256'h0);
        send_msg(16, 1'b1, 1'b0, 1'b0, 256'h0);
        send_msg(15, 1'b1, 1'b0, 1'b0, 256'h0);
        send_msg(13, 1'b0, 1'b0, 1'b0, 256'h0);
        send_msg(20, 1'b1, 1'b1, 1'b0, 256'h0);
        send_msg(0, 1'b0, 1'b1, 1'b1, DIG_EMPTY);

        // Reset while the core is working, then a stale blk_done.
        core_en = 1'b0;
        wait_idle();
        exp_blk_q.push_back({32'h8000_0000, 480'h0});
        exp_h_q.push_back(IV);
        @(negedge clk);
        start = 1'b1;
        msg_len = '0;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!blk_start && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!blk_start) fail_now("abort_blk_start");
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 512'(busy), 512'(0));
        chk("abort_in_ready", 512'(in_ready), 512'(0));
        chk("abort_blk_data", blk_data, 512'(0));
        chk("abort_blk_h", 512'(blk_h), 512'(0));
        chk("abort_digest", 512'(digest), 512'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        blk_hash = {8{$urandom}};
        blk_done = 1'b1;
        @(negedge clk);
        blk_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("stale_done", 512'(done), 512'(0));
            chk("stale_blk_start", 512'(blk_start), 512'(0));
            chk("stale_busy", 512'(busy), 512'(0));
            @(negedge clk);
        end
        core_en = 1'b1;
        send_msg(0, 1'b0, 1'b0, 1'b1, DIG_EMPTY);

        for (int t = 0; t < 10; t++) begin
            send_msg($urandom_range(0, 40), 1'($urandom), 1'($urandom), 1'b0, 256'h0);
        end

        repeat (5) @(negedge clk);
        chk("blk_queue_drained", 512'(exp_blk_q.size()), 512'(0));
        chk("dig_queue_drained", 512'(exp_dig_q.size()), 512'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
